// File: rtl/ssp_rx_ctrl.sv
// SSP serial receive controller: synchronises the external serial link, assembles MSB-first frames and pushes them to a FIFO.
// Optional macro SSP_RX_OVERRUN_EN enables the sticky overrun flag for frames dropped on a full FIFO.
module ssp_rx_ctrl #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              pclk,
    input  logic              clr_b,
    input  logic              sspclkin,
    input  logic              sspfssin,
    input  logic              ssprxd,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic              psel,
    input  logic              pwrite,
    output logic [DATA_W-1:0] rxdata,
    output logic              rx_wr_en,
    output logic              rx_rd_en,
    output logic              ssprxintr,
    output logic              rx_overrun
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_W-1:0]       shift_reg;
    logic [SYNC_STAGES-1:0]  clk_sync;
    logic [SYNC_STAGES-1:0]  fss_sync;
    logic [SYNC_STAGES-1:0]  rxd_sync;
    logic                    clk_prev;
    logic                    rd_prev;
    logic                    clk_s;
    logic                    fss_s;
    logic                    rxd_s;
    logic                    sample;
    logic                    apb_read;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign fss_s    = fss_sync[SYNC_STAGES-1];
    assign rxd_s    = rxd_sync[SYNC_STAGES-1];
    assign sample   = clk_prev & ~clk_s;
    assign apb_read = psel & ~pwrite;

    // Bit 0 of each chain takes the raw pin; only the last stage is ever used.
    always_ff @(posedge pclk) begin
        if (clr_b) begin
            clk_sync <= '0;
            fss_sync <= '0;
            rxd_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync[0] <= sspclkin;
            fss_sync[0] <= sspfssin;
            rxd_sync[0] <= ssprxd;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i] <= clk_sync[i-1];
                fss_sync[i] <= fss_sync[i-1];
                rxd_sync[i] <= rxd_sync[i-1];
            end
            clk_prev <= clk_s;
        end
    end

    always_ff @(posedge pclk) begin
        if (clr_b) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rxdata    <= '0;
            rx_wr_en  <= 1'b0;
        end else begin
            rx_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample && fss_s) begin
                        state     <= SHIFT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                SHIFT: begin
                    // A frame sync mid-frame restarts reception from scratch.
                    if (sample && fss_s) begin
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end else if (sample) begin
                        shift_reg <= {shift_reg[DATA_W-2:0], rxd_s};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= PUSH;
                        end
                    end
                end
                PUSH: begin
                    if (!fifo_full) begin
                        rxdata   <= shift_reg;
                        rx_wr_en <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pop strobe fires only on the first cycle of a read access.
    always_ff @(posedge pclk) begin
        if (clr_b) begin
            rd_prev   <= 1'b0;
            rx_rd_en  <= 1'b0;
            ssprxintr <= 1'b0;
        end else begin
            rd_prev   <= apb_read;
            rx_rd_en  <= apb_read & ~rd_prev & ~fifo_empty;
            ssprxintr <= ~fifo_empty;
        end
    end

`ifdef SSP_RX_OVERRUN_EN
    logic overrun_q;

    // A drop in the same cycle as a read wins so the event is never lost.
    always_ff @(posedge pclk) begin
        if (clr_b) begin
            overrun_q <= 1'b0;
        end else if (state == PUSH && fifo_full) begin
            overrun_q <= 1'b1;
        end else if (apb_read) begin
            overrun_q <= 1'b0;
        end
    end

    assign rx_overrun = overrun_q;
`else
    assign rx_overrun = 1'b0;
`endif

endmodule
